// File: rtl/approx_mult_err_eval_pkg.sv
// approx_mult_err_eval_pkg: FSM encoding, width helpers and latency limit shared by the error evaluator (ERR_BIAS_EN adds signed bias sum)
package approx_mult_err_eval_pkg;
  localparam logic [1:0] S_IDLE = 2'd0, S_SWEEP = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam int LAT_MAX = 4;
  function automatic int pw(input int w);
    return 2 * w;
  endfunction
  function automatic int sw(input int w);
    return 4 * w;
  endfunction
  function automatic int cw(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/approx_mult_err_eval_if.sv
// approx_mult_err_eval_if: control, result and multiplier-side signals of the error evaluator (ERR_BIAS_EN adds sum_err)
interface approx_mult_err_eval_if
  import approx_mult_err_eval_pkg::*;
  #(parameter int W = 4);
  logic start, busy, done;
  logic [W-1:0] dut_a, dut_b;
  logic [pw(W)-1:0] dut_r;
  logic [cw(W)-1:0] err_count;
  logic [sw(W)-1:0] sum_ed;
  logic [pw(W)-1:0] max_ed;
`ifdef ERR_BIAS_EN
  logic signed [sw(W):0] sum_err;
  modport master(output start, dut_r, input busy, done, dut_a, dut_b, err_count, sum_ed, max_ed, sum_err);
  modport slave(input start, dut_r, output busy, done, dut_a, dut_b, err_count, sum_ed, max_ed, sum_err);
`else
  modport master(output start, dut_r, input busy, done, dut_a, dut_b, err_count, sum_ed, max_ed);
  modport slave(input start, dut_r, output busy, done, dut_a, dut_b, err_count, sum_ed, max_ed);
`endif
endinterface

// File: rtl/approx_mult_err_acc.sv
// approx_mult_err_acc: compare-and-accumulate stage of the error evaluator (ERR_BIAS_EN adds signed bias sum)
module approx_mult_err_acc
  import approx_mult_err_eval_pkg::*;
  #(parameter int W = 4)
  (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic vld,
  input logic [2*W-1:0] r,
  input logic [2*W-1:0] x,
  output logic [2*W:0] err_count,
  output logic [4*W-1:0] sum_ed,
  output logic [2*W-1:0] max_ed
`ifdef ERR_BIAS_EN
  , output logic signed [4*W:0] sum_err
`endif
  );
  localparam int PW = pw(W), SW = sw(W), CW = cw(W);
  logic [PW-1:0] ed;
  assign ed = r >= x ? r - x : x - r;
  always_ff @(posedge clk)
    if (rst || clr) begin
      err_count <= '0;
      sum_ed <= '0;
      max_ed <= '0;
    end else if (vld) begin
      err_count <= err_count + {{(CW-1){1'b0}}, |ed};
      sum_ed <= sum_ed + {{(SW-PW){1'b0}}, ed};
      max_ed <= ed > max_ed ? ed : max_ed;
    end
`ifdef ERR_BIAS_EN
  always_ff @(posedge clk)
    if (rst || clr) sum_err <= '0;
    else if (vld) sum_err <= sum_err + $signed({{(PW+1){1'b0}}, r}) - $signed({{(PW+1){1'b0}}, x});
`endif
endmodule

// File: rtl/approx_mult_err_eval.sv
// approx_mult_err_eval: exhaustive operand sweep of a LAT-cycle multiplier with error metrics accumulation (ERR_BIAS_EN adds sum_err)
module approx_mult_err_eval
  import approx_mult_err_eval_pkg::*;
  #(parameter int W = 4, parameter int LAT = 0)
  (
  input logic clk,
  input logic rst,
  approx_mult_err_eval_if.slave bus
  );
  localparam int PW = pw(W);
  logic [1:0] state;
  logic [PW-1:0] idx, x0, al_x;
  logic al_v, drain_last, last, v0;
  assign last = &idx;
  assign v0 = state == S_SWEEP;
  assign x0 = {{W{1'b0}}, idx[W-1:0]} * {{W{1'b0}}, idx[PW-1:W]};
  assign bus.dut_a = idx[W-1:0];
  assign bus.dut_b = idx[PW-1:W];
  assign bus.busy = v0 || state == S_DRAIN;
  assign bus.done = state == S_DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      idx <= '0;
    end else begin
      state <= state == S_IDLE ? (bus.start ? S_SWEEP : S_IDLE) :
               state == S_SWEEP ? (!last ? S_SWEEP : LAT == 0 ? S_DONE : S_DRAIN) :
               state == S_DRAIN ? (drain_last ? S_DONE : S_DRAIN) : S_IDLE;
      idx <= v0 && !last ? idx + PW'(1) : '0;
    end
  generate
    if (LAT == 0) begin : g_comb
      assign al_v = v0;
      assign al_x = x0;
      assign drain_last = 1'b1;
    end else begin : g_pipe
      logic [LAT-1:0] vp;
      logic [PW-1:0] xp [LAT];
      always_ff @(posedge clk)
        if (rst) begin
          vp <= '0;
          for (int k = 0; k < LAT; k++) xp[k] <= '0;
        end else begin
          vp <= LAT'({vp, v0});
          xp[0] <= x0;
          for (int k = 1; k < LAT; k++) xp[k] <= xp[k-1];
        end
      assign al_v = vp[LAT-1];
      assign al_x = xp[LAT-1];
      assign drain_last = LAT'(vp << 1) == '0;
    end
  endgenerate
  approx_mult_err_acc #(.W(W)) u_acc (
    .clk(clk),
    .rst(rst),
    .clr(state == S_IDLE && bus.start),
    .vld(al_v),
    .r(bus.dut_r),
    .x(al_x),
    .err_count(bus.err_count),
    .sum_ed(bus.sum_ed),
    .max_ed(bus.max_ed)
`ifdef ERR_BIAS_EN
    , .sum_err(bus.sum_err)
`endif
  );
endmodule

// File: tb/tb_approx_mult_err_eval.sv
// tb_approx_mult_err_eval: scoreboard bench for the error evaluator at LAT=0 and LAT=2 (ERR_BIAS_EN also checks sum_err)
module tb_approx_mult_err_eval;
  typedef struct {
    int inst;
    int ec;
    int se;
    int me;
    int sr;
    int cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, tests = 0, fails = 0;
  logic [1:0] st = '0, dn, bz;
  int md[2] = '{0, 0};
  int ts[2] = '{-1, -1};
  int bcnt[2] = '{0, 0};
  int dcnt[2] = '{0, 0};
  logic [7:0] r2a = '0, r2b = '0;
  logic [7:0] pr[2], me[2];
  logic [8:0] ec[2];
  logic [15:0] se[2];
  exp_t q[$];
  approx_mult_err_eval_if #(.W(4)) b0();
  approx_mult_err_eval_if #(.W(4)) b2();
  approx_mult_err_eval #(.W(4), .LAT(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  approx_mult_err_eval #(.W(4), .LAT(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  function automatic logic [7:0] model(input int m, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = {4'd0, a} * {4'd0, b};
    return m == 1 ? 8'd0 : m == 2 ? (p | 8'd1) : p;
  endfunction
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign b0.start = st[0];
  assign b2.start = st[1];
  assign b0.dut_r = model(md[0], b0.dut_a, b0.dut_b);
  always @(posedge clk) begin
    r2a <= model(md[1], b2.dut_a, b2.dut_b);
    r2b <= r2a;
  end
  assign b2.dut_r = r2b;
  assign dn = {b2.done, b0.done};
  assign bz = {b2.busy, b0.busy};
  assign pr[0] = {b0.dut_b, b0.dut_a};
  assign pr[1] = {b2.dut_b, b2.dut_a};
  assign ec[0] = b0.err_count;
  assign ec[1] = b2.err_count;
  assign se[0] = b0.sum_ed;
  assign se[1] = b2.sum_ed;
  assign me[0] = b0.max_ed;
  assign me[1] = b2.max_ed;
`ifdef ERR_BIAS_EN
  logic signed [16:0] sr[2];
  assign sr[0] = b0.sum_err;
  assign sr[1] = b2.sum_err;
`endif
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    int k;
    exp_t e;
    for (int j = 0; j < 2; j++) begin
      k = ts[j] < 0 ? -1 : cyc - ts[j] - 1;
      chk($sformatf("pair%0d@%0d", j, cyc), pr[j], (k >= 0 && k < 256) ? k : 0);
      bcnt[j] = rst ? 0 : bcnt[j] + int'(bz[j]);
      if (dn[j]) begin
        dcnt[j]++;
        if (q.size() == 0 || q[0].inst != j) chk($sformatf("unexpected_done%0d@%0d", j, cyc), 1, 0);
        else begin
          e = q.pop_front();
          chk($sformatf("done_cycle%0d", j), cyc, e.cyc);
          chk($sformatf("err_count%0d", j), ec[j], e.ec);
          chk($sformatf("sum_ed%0d", j), se[j], e.se);
          chk($sformatf("max_ed%0d", j), me[j], e.me);
`ifdef ERR_BIAS_EN
          chk($sformatf("sum_err%0d", j), sr[j], e.sr);
`endif
          chk($sformatf("busy_cycles%0d", j), bcnt[j], j == 0 ? 256 : 258);
        end
        bcnt[j] = 0;
      end
    end
  end
  task automatic sweep(input int j, input int m, input int e_ec, input int e_se, input int e_me, input int e_sr, input bit rep);
    exp_t e;
    int d0;
    md[j] = m;
    @(posedge clk);
    #1;
    e.inst = j;
    e.ec = e_ec;
    e.se = e_se;
    e.me = e_me;
    e.sr = e_sr;
    e.cyc = cyc + 257 + (j == 0 ? 0 : 2);
    q.push_back(e);
    d0 = dcnt[j];
    ts[j] = cyc;
    st[j] = 1'b1;
    @(posedge clk);
    #1 st[j] = 1'b0;
    if (rep) begin
      repeat (49) @(posedge clk);
      #1 st[j] = 1'b1;
      @(posedge clk);
      #1 st[j] = 1'b0;
    end
    for (int n = 0; n < 400 && dcnt[j] == d0; n++) @(posedge clk);
    chk($sformatf("done_seen%0d", j), dcnt[j] - d0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic zero_chk(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s_busy%0d", tag, j), bz[j], 0);
      chk($sformatf("%s_done%0d", tag, j), dn[j], 0);
      chk($sformatf("%s_err_count%0d", tag, j), ec[j], 0);
      chk($sformatf("%s_sum_ed%0d", tag, j), se[j], 0);
      chk($sformatf("%s_max_ed%0d", tag, j), me[j], 0);
`ifdef ERR_BIAS_EN
      chk($sformatf("%s_sum_err%0d", tag, j), sr[j], 0);
`endif
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    zero_chk("reset");
    sweep(0, 0, 0, 0, 0, 0, 1'b0);
    sweep(0, 1, 225, 14400, 225, -14400, 1'b0);
    sweep(0, 2, 192, 192, 1, 192, 1'b0);
    sweep(1, 0, 0, 0, 0, 0, 1'b0);
    sweep(1, 1, 225, 14400, 225, -14400, 1'b0);
    sweep(0, 1, 225, 14400, 225, -14400, 1'b1);
    md[0] = 2;
    @(posedge clk);
    #1 ts[0] = cyc;
    st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ts[0] = -1;
    @(negedge clk);
    zero_chk("abort");
    sweep(0, 2, 192, 192, 1, 192, 1'b0);
    repeat (20) @(posedge clk);
    chk("pending_results", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
